// File: rtl/dbg_clk_sched.sv
// Debug clock scheduler: walks NUM_CLKS divider limit selections through every
// combination in odometer order and freezes the dividers around each change.
module dbg_clk_sched #(
   parameter int unsigned NUM_CLKS  = 4,
   parameter int unsigned NUM_LIMS  = 7,
   parameter int unsigned IDX_WDH   = 3,
   parameter int unsigned CLK_WDH   = 17,
   parameter int unsigned DWELL     = 250000,
   parameter int unsigned SETTLE    = 4,
   parameter int unsigned COMBO_WDH = 12
) (
   input  logic                        i_clk,
   input  logic                        reset,
   input  logic                        i_enable,
   input  logic                        i_hold,
   input  logic                        i_step,
   output logic [NUM_CLKS*IDX_WDH-1:0] o_lims_idxs,
   output logic [NUM_CLKS*CLK_WDH-1:0] o_lim_vals,
   output logic                        o_changing,
   output logic                        o_load,
   output logic                        o_wrap,
   output logic [COMBO_WDH-1:0]        o_combo_cnt
);
   localparam int unsigned DW_WDH = $clog2(DWELL + 1);
   localparam int unsigned ST_WDH = $clog2(SETTLE + 1);
   localparam logic [DW_WDH-1:0]  DWELL_C  = DW_WDH'(DWELL);
   localparam logic [ST_WDH-1:0]  SETTLE_C = ST_WDH'(SETTLE);
   localparam logic [IDX_WDH-1:0] LAST_IDX = IDX_WDH'(NUM_LIMS - 1);
   localparam logic [NUM_CLKS*CLK_WDH-1:0] VALS_RST = {NUM_CLKS{CLK_WDH'(2)}};

   typedef enum logic [2:0] {S_IDLE, S_DWELL, S_FREEZE, S_LOAD, S_SETTLE} state_t;

   // Limit table: 2^(p-1) for the primes 2,3,5,7,11,13,17.
   function automatic logic [CLK_WDH-1:0] rom_val(input logic [IDX_WDH-1:0] idx);
      logic [CLK_WDH-1:0] v;
      case (int'(idx))
         1:       v = CLK_WDH'(4);
         2:       v = CLK_WDH'(16);
         3:       v = CLK_WDH'(64);
         4:       v = CLK_WDH'(1024);
         5:       v = CLK_WDH'(4096);
         6:       v = CLK_WDH'(65536);
         default: v = CLK_WDH'(2);
      endcase
      return v;
   endfunction

   state_t                      state_q;
   logic [DW_WDH-1:0]           dcnt_q;
   logic [ST_WDH-1:0]           scnt_q;
   logic [IDX_WDH-1:0]          idx_q [NUM_CLKS];
   logic [IDX_WDH-1:0]          idx_d [NUM_CLKS];
   logic [NUM_CLKS*CLK_WDH-1:0] vals_q, vals_d;
   logic                        changing_q, load_q, wrap_q, wrap_d, carry_c;
   logic [COMBO_WDH-1:0]        combo_q;

   // Odometer increment; carry out of the top digit marks the wrap.
   always_comb begin
      carry_c = 1'b1;
      idx_d   = idx_q;
      vals_d  = '0;
      for (int unsigned k = 0; k < NUM_CLKS; k++) begin
         if (carry_c) begin
            if (idx_q[k] == LAST_IDX) begin
               idx_d[k] = '0;
            end else begin
               idx_d[k] = idx_q[k] + IDX_WDH'(1);
               carry_c  = 1'b0;
            end
         end
         vals_d[k*CLK_WDH +: CLK_WDH] = rom_val(idx_d[k]);
      end
      wrap_d = carry_c;
   end

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         dcnt_q     <= '0;
         scnt_q     <= '0;
         for (int unsigned k = 0; k < NUM_CLKS; k++) idx_q[k] <= '0;
         vals_q     <= VALS_RST;
         changing_q <= 1'b0;
         load_q     <= 1'b0;
         wrap_q     <= 1'b0;
         combo_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_enable) begin
                  state_q <= S_DWELL;
                  dcnt_q  <= DW_WDH'(1);
               end
            end
            S_DWELL: begin
               if (!i_enable) begin
                  state_q <= S_IDLE;
               end else if (i_step || (dcnt_q == DWELL_C && !i_hold)) begin
                  state_q    <= S_FREEZE;
                  changing_q <= 1'b1;
               end else if (!i_hold) begin
                  dcnt_q <= dcnt_q + DW_WDH'(1);
               end
            end
            S_FREEZE: begin
               idx_q   <= idx_d;
               vals_q  <= vals_d;
               combo_q <= combo_q + COMBO_WDH'(1);
               load_q  <= 1'b1;
               wrap_q  <= wrap_d;
               state_q <= S_LOAD;
            end
            S_LOAD: begin
               load_q  <= 1'b0;
               wrap_q  <= 1'b0;
               scnt_q  <= ST_WDH'(1);
               state_q <= S_SETTLE;
            end
            S_SETTLE: begin
               if (scnt_q == SETTLE_C) begin
                  changing_q <= 1'b0;
                  if (i_enable) begin
                     state_q <= S_DWELL;
                     dcnt_q  <= DW_WDH'(1);
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  scnt_q <= scnt_q + ST_WDH'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      o_lims_idxs = '0;
      for (int unsigned k = 0; k < NUM_CLKS; k++) o_lims_idxs[k*IDX_WDH +: IDX_WDH] = idx_q[k];
   end

   assign o_lim_vals  = vals_q;
   assign o_changing  = changing_q;
   assign o_load      = load_q;
   assign o_wrap      = wrap_q;
   assign o_combo_cnt = combo_q;

endmodule
